pb_debounce: RTL and testbench
==============================

Name: pb_debounce

Overview:
Conditions the raw active-low board push buttons before they reach the Nios switch PIO and the direct LED path. It provides:
- a 2-flop synchroniser per button;
- per-button debounce with a stable-count filter;
- active-high debounced levels, plus single-cycle press, release and long-hold event pulses.

It sits between the PB pins and the nios_setup switch PIO input / USER_LED logic, in the SYS_CLK50M domain.

Parameters:
NUM_PB, 4, number of button channels
DB_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range 2 to 2^24-1
HOLD_CYCLES, 50000000, cycles a debounced press must persist before PB_HOLD fires (1 s); must be greater than 0

Ports:
SYS_CLK50M  input  1  system clock, 50 MHz
RESET_EXPN  input  1  reset, synchronous, active-high
PB  input  NUM_PB  raw buttons, active-low (0 = pressed), asynchronous
PB_LEVEL  output  NUM_PB  debounced state, active-high (1 = pressed)
PB_PRESS  output  NUM_PB  1-cycle pulse on accepted press
PB_RELEASE  output  NUM_PB  1-cycle pulse on accepted release
PB_HOLD  output  NUM_PB  1-cycle pulse, once per press, after HOLD_CYCLES held

Behaviour:
- One clock (SYS_CLK50M). Reset is synchronous and active-high on RESET_EXPN, sampled on the rising edge.
- Reset values:
  - sync flops = 1 (released);
  - PB_LEVEL, PB_PRESS, PB_RELEASE, PB_HOLD = 0;
  - all counters = 0;
  - all channels in state UP.
- Synchroniser: s1 <= PB[i]; s2 <= s1. The filter uses only p = ~s2.
- Per-channel FSM states:
  - UP: level 0. If p=1, go to UP_CHK with cnt=1.
  - UP_CHK: if p=0, return to UP with cnt=0 (glitch rejected). Else if cnt == DB_CYCLES-1, go to DOWN, set level=1, pulse PB_PRESS, clear hold_cnt. Else cnt+1.
  - DOWN: level 1. If p=0, go to DN_CHK with cnt=1. hold_cnt runs in DOWN and DN_CHK.
  - DN_CHK: if p=1, return to DOWN with cnt=0. Else if cnt == DB_CYCLES-1, go to UP, set level=0, pulse PB_RELEASE. Else cnt+1.
- Latency: a raw change that stays stable updates PB_LEVEL and fires the edge pulse exactly DB_CYCLES+2 rising edges after the first edge that samples the new raw value. The 2 extra edges are the synchroniser.
- Glitches: any glitch shorter than DB_CYCLES cycles (after synchronisation) produces no output change. The counter restarts from zero on every glitch.
- Hold counting:
  - hold_cnt increments while level=1 and saturates at HOLD_CYCLES.
  - PB_HOLD pulses on the cycle hold_cnt reaches HOLD_CYCLES-1 → HOLD_CYCLES, once per press.
  - A release clears hold_cnt; the next press re-arms it.
  - If the release is accepted on the same edge the hold would fire, the release wins and PB_HOLD is suppressed.
- Counter widths: cnt is $clog2(DB_CYCLES+1) bits; hold_cnt is $clog2(HOLD_CYCLES+1) bits. Neither counter wraps: cnt is bounded by the FSM, hold_cnt saturates.
- Channel independence: channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Pulse exclusivity: PB_PRESS and PB_RELEASE are never both 1 on the same channel in the same cycle.
- Reset mid-operation: discards any in-progress filtering and hold counting. Outputs are 0 on the first edge after reset is sampled. After reset deassertion, a button still held is re-detected as a fresh press after DB_CYCLES+2 edges.

Decomposition:
- Shared package pb_pkg:
  - state encoding constants (UP=2'd0, UP_CHK=2'd1, DOWN=2'd2, DN_CHK=2'd3);
  - default DB_CYCLES and HOLD_CYCLES constants for the 50 MHz board.
- Sub-module pb_debounce_chan: one channel (synchroniser, FSM, both counters, three pulse outputs). pb_debounce instantiates NUM_PB copies in a generate loop and concatenates their outputs.

Test Plan (bench overrides DB_CYCLES=8, HOLD_CYCLES=32):
- Reset with PB=4'hF held → all outputs 0 throughout; after deassert, PB_LEVEL stays 4'h0 for 100 cycles.
- PB[0] driven 0 and held → PB_PRESS[0] pulses exactly once at edge 10 after the change; PB_LEVEL[0]=1 from then on. Driving PB[0] back to 1 → PB_RELEASE[0] pulses once at edge 10 after that change; PB_LEVEL[0] returns to 0.
- PB[1] bounced low for 5 cycles, high 2, low 7, high → no pulses and PB_LEVEL[1]=0. Then low 20 cycles → press accepted 10 edges after the last falling transition.
- PB[2] held low 60 cycles → PB_PRESS[2] once; PB_HOLD[2] once, 32 cycles after PB_PRESS[2]; no second PB_HOLD. Release then press again → PB_HOLD[2] fires again.
- PB=4'h0 in one cycle, all held → PB_PRESS=4'hF in the same cycle. Release PB[3] only → PB_RELEASE=4'h8, and PB_LEVEL=4'h7 afterwards.
- PB[0] held low; RESET_EXPN asserted 3 cycles mid-press → outputs 0 on the next edge. After deassert, PB_PRESS[0] pulses again 10 edges later.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared definitions for the push-button conditioning block:
// per-channel FSM state encoding and default timing for the 50 MHz board.
package pb_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    UP_CHK = 2'd1,
    DOWN   = 2'd2,
    DN_CHK = 2'd3
  } pb_state_t;

  // 10 ms debounce window and 1 s long-hold threshold at 50 MHz
  localparam int unsigned PB_DB_CYCLES_DEF   = 500000;
  localparam int unsigned PB_HOLD_CYCLES_DEF = 50000000;

endpackage

// File: rtl/pb_debounce_chan.sv
// One push-button channel: 2-flop synchroniser, stable-count debounce FSM,
// long-hold timer and registered press/release/hold pulses.
//
// state  | meaning
// UP     | debounced released, waiting for a press
// UP_CHK | press seen, counting stable cycles before accepting it
// DOWN   | debounced pressed, hold timer running
// DN_CHK | release seen, counting stable cycles; hold timer still running
module pb_debounce_chan
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = PB_DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = PB_HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic s1, s2;
  logic p;

  pb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              level_q, level_nxt;
  logic              press_q, press_nxt;
  logic              release_q, release_nxt;
  logic              hold_q, hold_nxt;

  // Sync flops reset to the released (high) level so reset never looks like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= pb_raw;
      s2 <= s1;
    end
  end

  assign p = ~s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UP;
      cnt       <= '0;
      hold_cnt  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      hold_q    <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_cnt_nxt = hold_cnt;
    level_nxt    = level_q;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    hold_nxt     = 1'b0;

    // Saturating hold timer; the release branch below overrides it
    if ((state == DOWN || state == DN_CHK) && hold_cnt != HOLD_MAX) begin
      hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      hold_nxt     = (hold_cnt == HOLD_PRE);
    end

    case (state)
      UP: begin
        level_nxt = 1'b0;
        if (p) begin
          state_nxt = UP_CHK;
          cnt_nxt   = CNT_W'(1);
        end
      end
      UP_CHK: begin
        if (!p) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = DOWN;
          cnt_nxt      = '0;
          level_nxt    = 1'b1;
          press_nxt    = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        level_nxt = 1'b1;
        if (!p) begin
          state_nxt = DN_CHK;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DN_CHK: begin
        if (p) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = UP;
          cnt_nxt      = '0;
          level_nxt    = 1'b0;
          release_nxt  = 1'b1;
          hold_cnt_nxt = '0;
          hold_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = UP;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;

endmodule

// File: rtl/pb_debounce.sv
// Push-button conditioning: NUM_PB independent debounce channels between the
// raw active-low PB pins and the switch PIO / LED logic.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned NUM_PB      = 4,
  parameter int unsigned DB_CYCLES   = PB_DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = PB_HOLD_CYCLES_DEF
) (
  input  logic              SYS_CLK50M,
  input  logic              RESET_EXPN,
  input  logic [NUM_PB-1:0] PB,
  output logic [NUM_PB-1:0] PB_LEVEL,
  output logic [NUM_PB-1:0] PB_PRESS,
  output logic [NUM_PB-1:0] PB_RELEASE,
  output logic [NUM_PB-1:0] PB_HOLD
);

  for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
    pb_debounce_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk          (SYS_CLK50M),
      .rst          (RESET_EXPN),
      .pb_raw       (PB[i]),
      .level        (PB_LEVEL[i]),
      .press_pulse  (PB_PRESS[i]),
      .release_pulse(PB_RELEASE[i]),
      .hold_pulse   (PB_HOLD[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce with short debounce/hold windows.
// Expected pulses are scheduled into a queue when stimulus is driven.
module tb_pb_debounce;

  localparam int NUM_PB = 4;
  localparam int DB     = 8;
  localparam int HOLD   = 32;
  localparam int LAT    = DB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pb  = 4'hF;
  logic [3:0] lvl, prs, rls, hld;

  always #10 clk = ~clk;

  pb_debounce #(
    .NUM_PB     (NUM_PB),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .SYS_CLK50M(clk),
    .RESET_EXPN(rst),
    .PB        (pb),
    .PB_LEVEL  (lvl),
    .PB_PRESS  (prs),
    .PB_RELEASE(rls),
    .PB_HOLD   (hld)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;
  } ev_t;

  typedef struct {
    logic [3:0] pb;
    int         dwell;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;
  } vec_t;

  ev_t        sb[$];
  vec_t       vecs[7];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_level = 4'h0;

  task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] h);
    ev_t e;
    e.cyc = at; e.press = p; e.rel = r; e.hold = h;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // One clock: sample just after the edge, retire due events, compare everything
  task automatic tick();
    logic [3:0] ep, er, eh;
    @(posedge clk);
    cyc++;
    #1;
    ep = 4'h0; er = 4'h0; eh = 4'h0;
    if (rst) begin
      sb.delete();
      exp_level = 4'h0;
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          ep |= sb[i].press;
          er |= sb[i].rel;
          eh |= sb[i].hold;
          sb.delete(i);
        end
      end
      exp_level = (exp_level | ep) & ~er;
    end
    cmp("level",   lvl, exp_level);
    cmp("press",   prs, ep);
    cmp("release", rls, er);
    cmp("hold",    hld, eh);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    vecs[0] = '{4'hE, 20, 4'h1, 4'h0, 4'h0};
    vecs[1] = '{4'hF, 20, 4'h0, 4'h1, 4'h0};
    vecs[2] = '{4'hD, DB, 4'h2, 4'h0, 4'h0};
    vecs[3] = '{4'hF, 20, 4'h0, 4'h2, 4'h0};
    vecs[4] = '{4'h0, 20, 4'hF, 4'h0, 4'h7};
    vecs[5] = '{4'h8, 20, 4'h0, 4'h8, 4'h0};
    vecs[6] = '{4'hF, 20, 4'h0, 4'h7, 4'h0};

    // Reset with buttons released, then quiet
    rst = 1'b1;
    pb  = 4'hF;
    idle(5);
    rst = 1'b0;
    idle(100);

    // Table: single press/release, minimum accepted pulse, simultaneous channels
    for (int v = 0; v < 7; v++) begin
      pb = vecs[v].pb;
      if ((vecs[v].press | vecs[v].rel) != 4'h0)
        expect_ev(cyc + LAT, vecs[v].press, vecs[v].rel, 4'h0);
      if (vecs[v].hold != 4'h0)
        expect_ev(cyc + LAT + HOLD, 4'h0, 4'h0, vecs[v].hold);
      idle(vecs[v].dwell);
    end

    // Bounce on PB[1]: low 5, high 2, low 7 (one short of acceptance) -> nothing
    pb[1] = 1'b0; idle(5);
    pb[1] = 1'b1; idle(2);
    pb[1] = 1'b0; idle(DB - 1);
    pb[1] = 1'b1; idle(20);
    pb[1] = 1'b0; expect_ev(cyc + LAT, 4'h2, 4'h0, 4'h0); idle(20);
    pb[1] = 1'b1; expect_ev(cyc + LAT, 4'h0, 4'h2, 4'h0); idle(20);

    // Long hold on PB[2], twice
    for (int k = 0; k < 2; k++) begin
      pb[2] = 1'b0;
      expect_ev(cyc + LAT, 4'h4, 4'h0, 4'h0);
      expect_ev(cyc + LAT + HOLD, 4'h0, 4'h0, 4'h4);
      idle(60);
      pb[2] = 1'b1;
      expect_ev(cyc + LAT, 4'h0, 4'h4, 4'h0);
      idle(20);
    end

    // Release accepted on the very edge the hold would fire: release only
    pb[2] = 1'b0; expect_ev(cyc + LAT, 4'h4, 4'h0, 4'h0); idle(HOLD);
    pb[2] = 1'b1; expect_ev(cyc + LAT, 4'h0, 4'h4, 4'h0); idle(20);

    // Reset in the middle of a press; button still held afterwards
    pb[0] = 1'b0; expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0); idle(15);
    rst = 1'b1; idle(3);
    rst = 1'b0; expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0); idle(20);
    pb[0] = 1'b1; expect_ev(cyc + LAT, 4'h0, 4'h1, 4'h0); idle(50);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
